// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the BCD calculator controller: key codes, operator
// and display encodings, sequencer states and small decode helpers.
package calc_sequencer_pkg;

   localparam int DEF_MAX_DIGITS  = 4;
   localparam int DEF_ALU_TIMEOUT = 64;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_CLR = 4'hC;
   localparam logic [3:0] KEY_EQ  = 4'hD;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;

   localparam logic [1:0] DISP_ZERO = 2'b00;
   localparam logic [1:0] DISP_OPN1 = 2'b01;
   localparam logic [1:0] DISP_OPN2 = 2'b10;
   localparam logic [1:0] DISP_RES  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTER1  = 3'd1,
      ST_OP_WAIT = 3'd2,
      ST_ENTER2  = 3'd3,
      ST_EXEC    = 3'd4,
      ST_RESULT  = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB);
   endfunction

   function automatic logic [1:0] op_of_key(input logic [3:0] k);
      return (k == KEY_SUB) ? OP_SUB : OP_ADD;
   endfunction

   function automatic logic [1:0] disp_of(input state_t s);
      logic [1:0] d;
      case (s)
         ST_ENTER1, ST_OP_WAIT: d = DISP_OPN1;
         ST_ENTER2, ST_EXEC:    d = DISP_OPN2;
         ST_RESULT:             d = DISP_RES;
         default:               d = DISP_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/calc_sequencer_timeout.sv
// ALU watchdog: down-counter loaded on alu_start, stopped by alu_done or
// clear, pulses expired when it runs out without being stopped.
module calc_sequencer_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;
   logic          run;

   // Load on start; count down while running; self-stop at terminal count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         cnt <= CW'(TIMEOUT - 1);
         run <= 1'b1;
      end else if (clear) begin
         run <= 1'b0;
      end else if (run) begin
         if (cnt == '0) begin
            run <= 1'b0;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Terminal-count compare: high for exactly one cycle per expiry.
   assign expired = run && (cnt == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Central controller for the 4-digit BCD calculator datapath.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | nothing entered, display shows zeros
// ST_ENTER1  | shifting digits into operand1
// ST_OP_WAIT | operator captured, waiting for first operand2 digit
// ST_ENTER2  | shifting digits into operand2
// ST_EXEC    | ALU running; only clear is accepted
// ST_RESULT  | result displayed; op chains, digit starts fresh
// ST_ERROR   | ALU error or timeout; only clear is accepted
module calc_sequencer
   import calc_sequencer_pkg::*;
#(
   parameter int MAX_DIGITS  = DEF_MAX_DIGITS,
   parameter int ALU_TIMEOUT = DEF_ALU_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       alu_done,
   input  logic       alu_err,
   output logic       digit_we,
   output logic       digit_sel,
   output logic [3:0] digit_val,
   output logic       opnd_clr,
   output logic       op_we,
   output logic [1:0] op_code,
   output logic       alu_start,
   output logic       res_load,
   output logic [1:0] disp_sel,
   output logic       busy,
   output logic       err
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [1:0]         pend_op, pend_op_n;
   // A digit typed in RESULT is replayed one cycle after the operand clear.
   logic               pdig_v, pdig_v_n;
   logic [3:0]         pdig, pdig_n;

   logic               digit_we_n, digit_sel_n, opnd_clr_n, op_we_n;
   logic               alu_start_n, res_load_n;
   logic [3:0]         digit_val_n;
   logic [1:0]         op_code_n;
   logic               key_clr, key_dig, key_op, key_eq, cnt_room;
   logic               tmr_clr, tmr_exp;

   assign key_clr  = key_valid && (key_code == KEY_CLR);
   assign key_dig  = key_valid && is_digit(key_code);
   assign key_op   = key_valid && is_op(key_code);
   assign key_eq   = key_valid && (key_code == KEY_EQ);
   assign cnt_room = cnt < CNT_W'(MAX_DIGITS);

   calc_sequencer_timeout #(.TIMEOUT(ALU_TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .start   (alu_start_n),
      .clear   (tmr_clr),
      .expired (tmr_exp)
   );

   // State, digit count, pending operator/digit and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pend_op   <= OP_NONE;
         pdig_v    <= 1'b0;
         pdig      <= 4'd0;
         digit_we  <= 1'b0;
         digit_sel <= 1'b0;
         digit_val <= 4'd0;
         opnd_clr  <= 1'b0;
         op_we     <= 1'b0;
         op_code   <= OP_NONE;
         alu_start <= 1'b0;
         res_load  <= 1'b0;
         disp_sel  <= DISP_ZERO;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pend_op   <= pend_op_n;
         pdig_v    <= pdig_v_n;
         pdig      <= pdig_n;
         digit_we  <= digit_we_n;
         digit_sel <= digit_sel_n;
         digit_val <= digit_val_n;
         opnd_clr  <= opnd_clr_n;
         op_we     <= op_we_n;
         op_code   <= op_code_n;
         alu_start <= alu_start_n;
         res_load  <= res_load_n;
         disp_sel  <= disp_of(state_n);
         busy      <= (state_n == ST_EXEC);
         err       <= (state_n == ST_ERROR);
      end
   end

   // Next-state and next-output decode; clear overrides everything.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pend_op_n   = pend_op;
      pdig_v_n    = 1'b0;
      pdig_n      = pdig;
      digit_we_n  = 1'b0;
      digit_sel_n = digit_sel;
      digit_val_n = digit_val;
      opnd_clr_n  = 1'b0;
      op_we_n     = 1'b0;
      op_code_n   = op_code;
      alu_start_n = 1'b0;
      res_load_n  = 1'b0;
      tmr_clr     = 1'b0;

      if (key_clr) begin
         state_n    = ST_IDLE;
         opnd_clr_n = 1'b1;
         cnt_n      = '0;
         pend_op_n  = OP_NONE;
         tmr_clr    = 1'b1;
      end else if (pdig_v) begin
         digit_we_n  = 1'b1;
         digit_sel_n = 1'b0;
         digit_val_n = pdig;
         cnt_n       = CNT_W'(1);
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (key_dig && (key_code != 4'd0)) begin
                  digit_we_n  = 1'b1;
                  digit_sel_n = 1'b0;
                  digit_val_n = key_code;
                  cnt_n       = CNT_W'(1);
                  state_n     = ST_ENTER1;
               end else if (key_op) begin
                  op_we_n   = 1'b1;
                  op_code_n = op_of_key(key_code);
                  state_n   = ST_OP_WAIT;
               end
            end
            ST_ENTER1, ST_ENTER2: begin
               if (key_dig) begin
                  if (cnt_room) begin
                     digit_we_n  = 1'b1;
                     digit_sel_n = (state == ST_ENTER2);
                     digit_val_n = key_code;
                     cnt_n       = cnt + CNT_W'(1);
                  end
               end else if (key_op && (state == ST_ENTER1)) begin
                  op_we_n   = 1'b1;
                  op_code_n = op_of_key(key_code);
                  cnt_n     = '0;
                  state_n   = ST_OP_WAIT;
               end else if ((key_op || key_eq) && (state == ST_ENTER2)) begin
                  alu_start_n = 1'b1;
                  pend_op_n   = key_op ? op_of_key(key_code) : OP_NONE;
                  state_n     = ST_EXEC;
               end
            end
            ST_OP_WAIT: begin
               if (key_op) begin
                  op_we_n   = 1'b1;
                  op_code_n = op_of_key(key_code);
               end else if (key_dig) begin
                  digit_we_n  = 1'b1;
                  digit_sel_n = 1'b1;
                  digit_val_n = key_code;
                  cnt_n       = CNT_W'(1);
                  state_n     = ST_ENTER2;
               end
            end
            ST_EXEC: begin
               if (alu_done) begin
                  tmr_clr = 1'b1;
                  if (alu_err) begin
                     state_n = ST_ERROR;
                  end else if (pend_op == OP_NONE) begin
                     state_n = ST_RESULT;
                  end else begin
                     res_load_n = 1'b1;
                     op_we_n    = 1'b1;
                     op_code_n  = pend_op;
                     pend_op_n  = OP_NONE;
                     cnt_n      = '0;
                     state_n    = ST_OP_WAIT;
                  end
               end else if (tmr_exp) begin
                  state_n = ST_ERROR;
               end
            end
            ST_RESULT: begin
               if (key_dig) begin
                  opnd_clr_n = 1'b1;
                  cnt_n      = '0;
                  state_n    = ST_ENTER1;
                  pdig_v_n   = (key_code != 4'd0);
                  pdig_n     = key_code;
               end else if (key_op) begin
                  res_load_n = 1'b1;
                  op_we_n    = 1'b1;
                  op_code_n  = op_of_key(key_code);
                  cnt_n      = '0;
                  state_n    = ST_OP_WAIT;
               end
            end
            ST_ERROR: begin
               state_n = ST_ERROR;
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

endmodule
